// File: rtl/buraq_mem_arbiter_if.sv
// Core/memory-side bundle for buraq_mem_arbiter.
// The master modport is the environment (core ports and memory macro).
// The slave modport is the arbiter itself.
interface buraq_mem_arbiter_if #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 15
);
  // instruction-fetch port
  logic                 inst_req;
  logic [AddrWidth-1:0] inst_addr;
  logic                 inst_gnt;
  logic                 inst_rvalid;
  logic [DataWidth-1:0] inst_rdata;

  // load/store port
  logic                 data_req;
  logic                 data_we;
  logic [2:0]           data_byte_en;
  logic [AddrWidth-1:0] data_addr;
  logic [DataWidth-1:0] data_wdata;
  logic                 data_gnt;
  logic                 data_rvalid;
  logic [DataWidth-1:0] data_rdata;

  // shared single-port memory
  logic                 mem_read_en;
  logic                 mem_write_en;
  logic [2:0]           mem_byte_en;
  logic [AddrWidth-1:0] mem_addr;
  logic [DataWidth-1:0] mem_wdata;
  logic [DataWidth-1:0] mem_rdata;

  modport master (
    output inst_req, inst_addr,
    output data_req, data_we, data_byte_en, data_addr, data_wdata,
    output mem_rdata,
    input  inst_gnt, inst_rvalid, inst_rdata,
    input  data_gnt, data_rvalid, data_rdata,
    input  mem_read_en, mem_write_en, mem_byte_en, mem_addr, mem_wdata
  );

  modport slave (
    input  inst_req, inst_addr,
    input  data_req, data_we, data_byte_en, data_addr, data_wdata,
    input  mem_rdata,
    output inst_gnt, inst_rvalid, inst_rdata,
    output data_gnt, data_rvalid, data_rdata,
    output mem_read_en, mem_write_en, mem_byte_en, mem_addr, mem_wdata
  );
endinterface

// File: rtl/buraq_mem_arbiter.sv
// buraq_mem_arbiter: shares one single-port synchronous memory (1-cycle read
// latency) between the fetch port and the load/store port of the Buraq core.
// Data accesses have fixed priority over fetch. Grants are combinational, so
// the winner reaches mem_* in the same cycle. An owner FSM remembers who was
// granted, so that the read response the next cycle goes to the right port.
// Optional feature: define BRQ_ARB_STARVE_GUARD_EN to add a saturating
// denied-fetch counter. When that counter reaches MaxWait, fetch wins for one
// cycle. Without the macro, data priority is strict and fetch can starve.
module buraq_mem_arbiter #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 15,
  parameter int unsigned MaxWait   = 4
) (
  input  logic                   brq_clk,
  input  logic                   brq_rst,
  buraq_mem_arbiter_if.slave     bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_INST = 2'b01,
    ST_DRD  = 2'b10,
    ST_DWR  = 2'b11
  } state_t;

  state_t state_r;
  logic   inst_gnt_s;
  logic   data_gnt_s;
  logic   force_fetch_s;
  logic   inst_rvalid_s;
  logic   data_rvalid_s;

`ifdef BRQ_ARB_STARVE_GUARD_EN
  localparam int unsigned CntW = (MaxWait < 1) ? 1 : $clog2(MaxWait + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxWait);

  logic [CntW-1:0] wait_cnt_r;

  // count consecutive cycles a pending fetch is denied, saturating at MaxWait
  always_ff @(posedge brq_clk) begin
    if (!brq_rst) begin
      wait_cnt_r <= {CntW{1'b0}};
    end else if (bus.inst_req && !inst_gnt_s) begin
      if (wait_cnt_r != CntMax) begin
        wait_cnt_r <= wait_cnt_r + CntW'(1);
      end else begin
        wait_cnt_r <= wait_cnt_r;
      end
    end else begin
      wait_cnt_r <= {CntW{1'b0}};
    end
  end

  assign force_fetch_s = bus.inst_req && (wait_cnt_r == CntMax);
`else
  assign force_fetch_s = 1'b0;
`endif

  // pick at most one winner per cycle; data first unless fetch is being forced
  always_comb begin
    inst_gnt_s = 1'b0;
    data_gnt_s = 1'b0;
    if (!brq_rst) begin
      inst_gnt_s = 1'b0;
      data_gnt_s = 1'b0;
    end else if (bus.inst_req && (force_fetch_s || !bus.data_req)) begin
      inst_gnt_s = 1'b1;
    end else if (bus.data_req) begin
      data_gnt_s = 1'b1;
    end else begin
      inst_gnt_s = 1'b0;
      data_gnt_s = 1'b0;
    end
  end

  // drive the memory with the winner's access in the grant cycle, else all-zero
  always_comb begin
    bus.mem_read_en  = 1'b0;
    bus.mem_write_en = 1'b0;
    bus.mem_byte_en  = 3'b000;
    bus.mem_addr     = {AddrWidth{1'b0}};
    bus.mem_wdata    = {DataWidth{1'b0}};
    if (inst_gnt_s) begin
      bus.mem_read_en = 1'b1;
      bus.mem_byte_en = 3'b010;
      bus.mem_addr    = bus.inst_addr;
    end else if (data_gnt_s) begin
      bus.mem_read_en  = !bus.data_we;
      bus.mem_write_en = bus.data_we;
      bus.mem_byte_en  = bus.data_byte_en;
      bus.mem_addr     = bus.data_addr;
      bus.mem_wdata    = bus.data_wdata;
    end else begin
      bus.mem_read_en  = 1'b0;
      bus.mem_write_en = 1'b0;
    end
  end

  // owner FSM: record this cycle's grant so next cycle's read data is routed
  always_ff @(posedge brq_clk) begin
    if (!brq_rst) begin
      state_r <= ST_IDLE;
    end else begin
      case ({inst_gnt_s, data_gnt_s})
        2'b10:   state_r <= ST_INST;
        2'b01:   state_r <= bus.data_we ? ST_DWR : ST_DRD;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign inst_rvalid_s = (state_r == ST_INST);
  assign data_rvalid_s = (state_r == ST_DRD);

  assign bus.inst_gnt    = inst_gnt_s;
  assign bus.data_gnt    = data_gnt_s;
  assign bus.inst_rvalid = inst_rvalid_s;
  assign bus.data_rvalid = data_rvalid_s;
  assign bus.inst_rdata  = inst_rvalid_s ? bus.mem_rdata : {DataWidth{1'b0}};
  assign bus.data_rdata  = data_rvalid_s ? bus.mem_rdata : {DataWidth{1'b0}};

endmodule

// File: tb/tb_buraq_mem_arbiter.sv
// Directed bench for buraq_mem_arbiter.
// A cycle-level reference model of the arbitration rules checks every output
// on every falling edge. Literal checks at key points pin the model itself.
module tb_buraq_mem_arbiter;
  localparam int DW   = 32;
  localparam int AW   = 15;
  localparam int MAXW = 4;
`ifdef BRQ_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  buraq_mem_arbiter_if #(.DataWidth(DW), .AddrWidth(AW)) bus ();

  buraq_mem_arbiter #(.DataWidth(DW), .AddrWidth(AW), .MaxWait(MAXW)) dut (
    .brq_clk (clk),
    .brq_rst (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state.
  // m_pend: 0 = no response due, 1 = fetch response due, 2 = load response due.
  // m_wait: number of consecutive cycles a fetch has been refused.
  int m_pend = 0;
  int m_wait = 0;
  bit check_en = 1'b0;

  // Model winner: 0 none, 1 fetch, 2 load, 3 store
  function automatic int pick();
    if (rst !== 1'b1) return 0;
    if (bus.inst_req && (!bus.data_req || (GUARD && m_wait >= MAXW))) return 1;
    if (bus.data_req) return bus.data_we ? 3 : 2;
    return 0;
  endfunction

  // model bookkeeping at each rising edge
  always @(posedge clk) begin
    int w;
    w = pick();
    if (rst !== 1'b1) begin
      m_pend <= 0;
      m_wait <= 0;
    end else begin
      m_pend <= (w == 1) ? 1 : ((w == 2) ? 2 : 0);
      if (bus.inst_req && w != 1) m_wait <= (m_wait < MAXW) ? m_wait + 1 : MAXW;
      else                        m_wait <= 0;
    end
  end

  // compare every DUT output against the model on the falling edge
  always @(negedge clk) begin
    int w;
    logic [31:0] e_addr, e_be, e_wd;
    if (check_en) begin
      w      = pick();
      e_addr = (w == 1) ? 32'(bus.inst_addr) : ((w >= 2) ? 32'(bus.data_addr) : 32'h0);
      e_be   = (w == 1) ? 32'h2 : ((w >= 2) ? 32'(bus.data_byte_en) : 32'h0);
      e_wd   = (w >= 2) ? bus.data_wdata : 32'h0;
      chk("m_inst_gnt",    32'(bus.inst_gnt),     32'(w == 1));
      chk("m_data_gnt",    32'(bus.data_gnt),     32'(w >= 2));
      chk("m_mem_read_en", 32'(bus.mem_read_en),  32'(w == 1 || w == 2));
      chk("m_mem_write_en",32'(bus.mem_write_en), 32'(w == 3));
      chk("m_mem_addr",    32'(bus.mem_addr),     e_addr);
      chk("m_mem_byte_en", 32'(bus.mem_byte_en),  e_be);
      chk("m_mem_wdata",   bus.mem_wdata,         e_wd);
      chk("m_inst_rvalid", 32'(bus.inst_rvalid),  32'(m_pend == 1));
      chk("m_data_rvalid", 32'(bus.data_rvalid),  32'(m_pend == 2));
      chk("m_inst_rdata",  bus.inst_rdata,        (m_pend == 1) ? bus.mem_rdata : 32'h0);
      chk("m_data_rdata",  bus.data_rdata,        (m_pend == 2) ? bus.mem_rdata : 32'h0);
    end
  end

  initial begin
    rst              = 1'b0;
    bus.inst_req     = 1'b0;
    bus.inst_addr    = 15'h0;
    bus.data_req     = 1'b0;
    bus.data_we      = 1'b0;
    bus.data_byte_en = 3'b000;
    bus.data_addr    = 15'h0;
    bus.data_wdata   = 32'h0;
    bus.mem_rdata    = 32'h0BAD_0BAD;

    // reset for two edges, then idle
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    check_en = 1'b1;
    @(negedge clk);
    chk("idle_inst_gnt",    32'(bus.inst_gnt),    32'h0);
    chk("idle_data_gnt",    32'(bus.data_gnt),    32'h0);
    chk("idle_mem_read_en", 32'(bus.mem_read_en), 32'h0);
    chk("idle_inst_rvalid", 32'(bus.inst_rvalid), 32'h0);
    chk("idle_data_rdata",  bus.data_rdata,       32'h0);

    // lone fetch
    @(posedge clk); #1;
    bus.inst_req  = 1'b1;
    bus.inst_addr = 15'h0010;
    @(negedge clk);
    chk("fetch_gnt",      32'(bus.inst_gnt),    32'h1);
    chk("fetch_read_en",  32'(bus.mem_read_en), 32'h1);
    chk("fetch_mem_addr", 32'(bus.mem_addr),    32'h10);
    @(posedge clk); #1;
    bus.inst_req  = 1'b0;
    bus.mem_rdata = 32'h0050_0093;
    @(negedge clk);
    chk("fetch_rvalid",   32'(bus.inst_rvalid), 32'h1);
    chk("fetch_rdata",    bus.inst_rdata,       32'h0050_0093);
    chk("fetch_d_rvalid", 32'(bus.data_rvalid), 32'h0);

    // conflict: store beats fetch, fetch follows
    @(posedge clk); #1;
    bus.inst_req     = 1'b1;
    bus.inst_addr    = 15'h0020;
    bus.data_req     = 1'b1;
    bus.data_we      = 1'b1;
    bus.data_byte_en = 3'b010;
    bus.data_addr    = 15'h0100;
    bus.data_wdata   = 32'hDEAD_BEEF;
    bus.mem_rdata    = 32'h7777_7777;
    @(negedge clk);
    chk("cf_data_gnt",  32'(bus.data_gnt),     32'h1);
    chk("cf_inst_gnt",  32'(bus.inst_gnt),     32'h0);
    chk("cf_write_en",  32'(bus.mem_write_en), 32'h1);
    chk("cf_mem_addr",  32'(bus.mem_addr),     32'h100);
    chk("cf_mem_wdata", bus.mem_wdata,         32'hDEAD_BEEF);
    @(posedge clk); #1;
    bus.data_req = 1'b0;
    @(negedge clk);
    chk("cf_fetch_gnt", 32'(bus.inst_gnt),    32'h1);
    chk("cf_no_drv",    32'(bus.data_rvalid), 32'h0);
    @(posedge clk); #1;
    bus.inst_req  = 1'b0;
    bus.mem_rdata = 32'h1111_1111;
    @(negedge clk);
    chk("cf_fetch_rdata", bus.inst_rdata, 32'h1111_1111);

    // load then fetch back-to-back
    @(posedge clk); #1;
    bus.data_req     = 1'b1;
    bus.data_we      = 1'b0;
    bus.data_byte_en = 3'b000;
    bus.data_addr    = 15'h0044;
    @(negedge clk);
    chk("lf_load_gnt", 32'(bus.data_gnt), 32'h1);
    @(posedge clk); #1;
    bus.data_req  = 1'b0;
    bus.inst_req  = 1'b1;
    bus.inst_addr = 15'h0048;
    bus.mem_rdata = 32'hA5A5_0001;
    @(negedge clk);
    chk("lf_d_rvalid",  32'(bus.data_rvalid), 32'h1);
    chk("lf_d_rdata",   bus.data_rdata,       32'hA5A5_0001);
    chk("lf_fetch_gnt", 32'(bus.inst_gnt),    32'h1);
    @(posedge clk); #1;
    bus.inst_req  = 1'b0;
    bus.mem_rdata = 32'h0000_0013;
    @(negedge clk);
    chk("lf_i_rvalid", 32'(bus.inst_rvalid), 32'h1);
    chk("lf_i_rdata",  bus.inst_rdata,       32'h0000_0013);
    chk("lf_d_idle",   32'(bus.data_rvalid), 32'h0);

    // starvation: both requests held for 20 cycles
    @(posedge clk); #1;
    bus.data_req  = 1'b1;
    bus.data_we   = 1'b0;
    bus.data_addr = 15'h0080;
    bus.inst_req  = 1'b1;
    bus.inst_addr = 15'h0090;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("starve_inst_gnt", 32'(bus.inst_gnt), GUARD ? 32'((k % 5) == 4) : 32'h0);
      chk("starve_data_gnt", 32'(bus.data_gnt), GUARD ? 32'((k % 5) != 4) : 32'h1);
      @(posedge clk); #1;
      bus.mem_rdata = 32'h1000_0000 + 32'(k);
    end
    bus.data_req = 1'b0;
    bus.inst_req = 1'b0;
    @(negedge clk);

    // reset mid-read: load granted, reset sampled at the next edge
    @(posedge clk); #1;
    bus.data_req  = 1'b1;
    bus.data_we   = 1'b0;
    bus.data_addr = 15'h0055;
    @(negedge clk);
    chk("rr_load_gnt", 32'(bus.data_gnt), 32'h1);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    bus.inst_req  = 1'b1;
    bus.mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("rr_d_rvalid",  32'(bus.data_rvalid), 32'h0);
    chk("rr_d_rdata",   bus.data_rdata,       32'h0);
    chk("rr_data_gnt",  32'(bus.data_gnt),    32'h0);
    chk("rr_inst_gnt",  32'(bus.inst_gnt),    32'h0);
    chk("rr_read_en",   32'(bus.mem_read_en), 32'h0);
    chk("rr_mem_addr",  32'(bus.mem_addr),    32'h0);
    @(posedge clk); #1;
    rst          = 1'b1;
    bus.data_req = 1'b0;
    bus.inst_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("end_i_rvalid", 32'(bus.inst_rvalid), 32'h0);

    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
